// File: rtl/st_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : st_sequencer_if
// Description : Control bundle between the store sequencer, the top-level
//               controller (start/stall) and the DataPath control port.
// Revision    : 1.0 - initial release
// ============================================================================
interface st_sequencer_if;
    logic       start;
    logic       stall;
    logic       PCout, Zlowout, MDRout, BAout, Cout, Rout;
    logic       MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
    logic       IncPC, Read, Write;
    logic [4:0] Operator;
    logic       Gra, Grb, Grc;
    logic       busy, done;
    logic [3:0] state;

    // Sequencer side: consumes start/stall, drives every control line
    modport master (
        input  start, stall,
        output PCout, Zlowout, MDRout, BAout, Cout, Rout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
        output IncPC, Read, Write, Operator, Gra, Grb, Grc,
        output busy, done, state
    );

    // Controller / DataPath side
    modport slave (
        output start, stall,
        input  PCout, Zlowout, MDRout, BAout, Cout, Rout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
        input  IncPC, Read, Write, Operator, Gra, Grb, Grc,
        input  busy, done, state
    );
endinterface
`default_nettype wire

// File: rtl/st_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : st_sequencer
// Description : Hard-wired Moore sequencer for "st Ra, C(Rb)". Fetches the
//               instruction, forms Rb+C in MAR, loads Ra into MDR and holds
//               Write for MEM_WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module st_sequencer #(
    parameter logic [4:0] ADD_OP   = 5'b00011,
    parameter int         MEM_WAIT = 1          // legal range 1..15
) (
    input  wire logic      clk,
    input  wire logic      clear,
    st_sequencer_if.master ctl
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0000,
        S_T0   = 4'b0111,
        S_T1   = 4'b1000,
        S_T2   = 4'b1001,
        S_T3   = 4'b1010,
        S_T4   = 4'b1011,
        S_T5   = 4'b1100,
        S_T6   = 4'b1101,
        S_T7   = 4'b1110,
        S_DONE = 4'b1111
    } state_t;

    localparam logic [3:0] C_WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // High only in the first cycle of T1, so PC is loaded exactly once even
    // when T1 is stretched by MEM_WAIT or by stall.
    logic       pcin_q, pcin_d;

    // State, wait counter and first-T1-cycle flag registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pcin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcin_q  <= pcin_d;
        end
    end

    // Next-state and wait-counter logic; stall freezes everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcin_d  = 1'b0;
        if (!ctl.stall) begin
            case (state_q)
                S_IDLE: if (ctl.start) state_d = S_T0;
                S_T0: begin
                    state_d = S_T1;
                    cnt_d   = C_WAIT_LOAD;
                    pcin_d  = 1'b1;
                end
                S_T1: begin
                    if (cnt_q == 4'd0) state_d = S_T2;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_T2: state_d = S_T3;
                S_T3: state_d = S_T4;
                S_T4: state_d = S_T5;
                S_T5: state_d = S_T6;
                S_T6: begin
                    state_d = S_T7;
                    cnt_d   = C_WAIT_LOAD;
                end
                S_T7: begin
                    if (cnt_q == 4'd0) state_d = S_DONE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state only
    always_comb begin
        ctl.PCout    = 1'b0;
        ctl.Zlowout  = 1'b0;
        ctl.MDRout   = 1'b0;
        ctl.BAout    = 1'b0;
        ctl.Cout     = 1'b0;
        ctl.Rout     = 1'b0;
        ctl.MARin    = 1'b0;
        ctl.Zin      = 1'b0;
        ctl.PCin     = 1'b0;
        ctl.MDRin    = 1'b0;
        ctl.IRin     = 1'b0;
        ctl.Yin      = 1'b0;
        ctl.Rin      = 1'b0;
        ctl.IncPC    = 1'b0;
        ctl.Read     = 1'b0;
        ctl.Write    = 1'b0;
        ctl.Operator = 5'b00000;
        ctl.Gra      = 1'b0;
        ctl.Grb      = 1'b0;
        ctl.Grc      = 1'b0;
        ctl.done     = 1'b0;
        ctl.busy     = (state_q != S_IDLE);
        ctl.state    = state_q;
        case (state_q)
            S_T0: begin
                ctl.PCout = 1'b1;
                ctl.MARin = 1'b1;
                ctl.IncPC = 1'b1;
                ctl.Zin   = 1'b1;
            end
            S_T1: begin
                ctl.Zlowout = pcin_q;
                ctl.PCin    = pcin_q;
                ctl.Read    = 1'b1;
                ctl.MDRin   = 1'b1;
            end
            S_T2: begin
                ctl.MDRout = 1'b1;
                ctl.IRin   = 1'b1;
            end
            S_T3: begin
                ctl.Grb   = 1'b1;
                ctl.BAout = 1'b1;
                ctl.Yin   = 1'b1;
            end
            S_T4: begin
                ctl.Cout     = 1'b1;
                ctl.Zin      = 1'b1;
                ctl.Operator = ADD_OP;
            end
            S_T5: begin
                ctl.Zlowout = 1'b1;
                ctl.MARin   = 1'b1;
            end
            S_T6: begin
                // Read stays low so MDR takes Ra from the bus
                ctl.Gra   = 1'b1;
                ctl.Rout  = 1'b1;
                ctl.MDRin = 1'b1;
            end
            S_T7:    ctl.Write = 1'b1;
            S_DONE:  ctl.done  = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_st_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_st_sequencer
// Description : Self-checking bench for st_sequencer (MEM_WAIT=1 and =3)
//               with a small DataPath model on the MEM_WAIT=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_st_sequencer;

    localparam logic [3:0] C_IDLE = 4'b0000, C_T0 = 4'b0111, C_T1 = 4'b1000,
                           C_T2 = 4'b1001, C_T3 = 4'b1010, C_T4 = 4'b1011,
                           C_T5 = 4'b1100, C_T6 = 4'b1101, C_T7 = 4'b1110,
                           C_DONE = 4'b1111;

    typedef struct packed {
        logic [3:0]  st;
        logic [25:0] ctl;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    exp_t sb1[$];
    exp_t sb3[$];
    int   n_busy, n_read, n_write, n_pcin;

    always #5 clk = ~clk;

    st_sequencer_if if1();
    st_sequencer_if if3();

    st_sequencer #(.MEM_WAIT(1)) dut1 (.clk(clk), .clear(clear), .ctl(if1));
    st_sequencer #(.MEM_WAIT(3)) dut3 (.clk(clk), .clear(clear), .ctl(if3));

    logic [25:0] ctl1, ctl3;
    assign ctl1 = {if1.PCout, if1.Zlowout, if1.MDRout, if1.BAout, if1.Cout, if1.Rout,
                   if1.MARin, if1.Zin, if1.PCin, if1.MDRin, if1.IRin, if1.Yin, if1.Rin,
                   if1.IncPC, if1.Read, if1.Write, if1.Gra, if1.Grb, if1.Grc,
                   if1.busy, if1.done, if1.Operator};
    assign ctl3 = {if3.PCout, if3.Zlowout, if3.MDRout, if3.BAout, if3.Cout, if3.Rout,
                   if3.MARin, if3.Zin, if3.PCin, if3.MDRin, if3.IRin, if3.Yin, if3.Rin,
                   if3.IncPC, if3.Read, if3.Write, if3.Gra, if3.Grb, if3.Grc,
                   if3.busy, if3.done, if3.Operator};

    // ---------------- DataPath model driven by the MEM_WAIT=3 sequencer ----
    logic [31:0] R [16];
    logic [31:0] mem [256];
    logic [31:0] PC, MAR, MDR, IR, Y, Z, dbus;
    logic [3:0]  rsel;
    bit          dp_init = 1'b0;
    localparam logic [31:0] C_INSTR = {5'b00100, 4'd4, 4'd2, 19'h00023};

    always_comb begin
        rsel = if3.Gra ? IR[26:23] : (if3.Grb ? IR[22:19] : (if3.Grc ? IR[18:15] : 4'd0));
        dbus = 32'd0;
        if (if3.PCout)   dbus = PC;
        if (if3.Zlowout) dbus = Z;
        if (if3.MDRout)  dbus = MDR;
        if (if3.Cout)    dbus = {{13{IR[18]}}, IR[18:0]};
        if (if3.Rout)    dbus = R[rsel];
        if (if3.BAout)   dbus = (rsel == 4'd0) ? 32'd0 : R[rsel];
    end

    always @(posedge clk) begin
        if (dp_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            for (int i = 0; i < 16; i++)  R[i]   <= 32'd0;
            mem[0] <= C_INSTR;
            R[2]   <= 32'h5;
            R[4]   <= 32'h99;
            PC <= 0; MAR <= 0; MDR <= 0; IR <= 0; Y <= 0; Z <= 0;
        end else begin
            if (if3.PCin)  PC  <= dbus;
            if (if3.MARin) MAR <= dbus;
            if (if3.IRin)  IR  <= dbus;
            if (if3.Yin)   Y   <= dbus;
            if (if3.MDRin) MDR <= if3.Read ? mem[MAR[7:0]] : dbus;
            if (if3.Zin)   Z   <= if3.IncPC ? dbus + 32'd1
                                 : ((if3.Operator == 5'b00011) ? Y + dbus : 32'd0);
            if (if3.Write) mem[MAR[7:0]] <= MDR;
        end
    end

    // Read and Write must never overlap on either instance
    always @(negedge clk) begin
        if (mon_en && !clear) begin
            tests++;
            if ((if1.Read & if1.Write) === 1'b1 || (if3.Read & if3.Write) === 1'b1) begin
                fails++;
                $display("FAIL rd_wr_overlap: dut1 R/W=%b%b dut3 R/W=%b%b required not both 1",
                         if1.Read, if1.Write, if3.Read, if3.Write);
            end
        end
    end

    // Expected control vector for a state, from the decode table
    function automatic logic [25:0] exp_ctrl(input logic [3:0] st, input logic first);
        logic pco, zlo, mdo, bao, co, ro, mai, zi, pci, mdi, iri, yi, ri;
        logic inc, rd, wr, ga, gb, gc, bz, dn;
        logic [4:0] op;
        {pco, zlo, mdo, bao, co, ro, mai, zi, pci, mdi, iri, yi, ri} = 13'd0;
        {inc, rd, wr, ga, gb, gc, dn} = 7'd0;
        op = 5'd0;
        bz = (st != C_IDLE);
        case (st)
            C_T0:   begin pco = 1; mai = 1; inc = 1; zi = 1; end
            C_T1:   begin zlo = first; pci = first; rd = 1; mdi = 1; end
            C_T2:   begin mdo = 1; iri = 1; end
            C_T3:   begin gb = 1; bao = 1; yi = 1; end
            C_T4:   begin co = 1; zi = 1; op = 5'b00011; end
            C_T5:   begin zlo = 1; mai = 1; end
            C_T6:   begin ga = 1; ro = 1; mdi = 1; end
            C_T7:   wr = 1;
            C_DONE: dn = 1;
            default: ;
        endcase
        return {pco, zlo, mdo, bao, co, ro, mai, zi, pci, mdi, iri, yi, ri,
                inc, rd, wr, ga, gb, gc, bz, dn, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle trace of one unstalled sequence, ending in IDLE
    task automatic push_trace(input int which, input int mw);
        exp_t q[$];
        logic [3:0] mid [5] = '{C_T2, C_T3, C_T4, C_T5, C_T6};
        q.push_back('{C_T0, exp_ctrl(C_T0, 1'b0)});
        for (int i = 0; i < mw; i++) q.push_back('{C_T1, exp_ctrl(C_T1, i == 0)});
        for (int i = 0; i < 5; i++)  q.push_back('{mid[i], exp_ctrl(mid[i], 1'b0)});
        for (int i = 0; i < mw; i++) q.push_back('{C_T7, exp_ctrl(C_T7, 1'b0)});
        q.push_back('{C_DONE, exp_ctrl(C_DONE, 1'b0)});
        q.push_back('{C_IDLE, exp_ctrl(C_IDLE, 1'b0)});
        foreach (q[i]) begin
            if (which == 1) sb1.push_back(q[i]);
            else            sb3.push_back(q[i]);
        end
    endtask

    // Launch a sequence and compare each cycle against the scoreboard
    task automatic run_sb(input int which, input int mw);
        exp_t e;
        int   left;
        n_busy = 0; n_read = 0; n_write = 0; n_pcin = 0;
        push_trace(which, mw);
        if (which == 1) if1.start = 1'b1; else if3.start = 1'b1;
        tick();
        if1.start = 1'b0; if3.start = 1'b0;
        left = (which == 1) ? sb1.size() : sb3.size();
        while (left > 0) begin
            e = (which == 1) ? sb1.pop_front() : sb3.pop_front();
            begin
                logic [3:0]  ast = (which == 1) ? if1.state : if3.state;
                logic [25:0] act = (which == 1) ? ctl1 : ctl3;
                tests++;
                if (ast !== e.st || act !== e.ctl) begin
                    fails++;
                    $display("FAIL trace_mw%0d: state=%b ctl=%h required state=%b ctl=%h",
                             mw, ast, act, e.st, e.ctl);
                end
                n_busy  += int'(act[6]);
                n_read  += int'(act[11]);
                n_write += int'(act[10]);
                n_pcin  += int'(act[17]);
            end
            left--;
            if (left > 0) tick();
        end
    endtask

    task automatic wait_st(input int which, input logic [3:0] tgt);
        int n = 0;
        while (((which == 1) ? if1.state : if3.state) !== tgt && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (((which == 1) ? if1.state : if3.state) !== tgt) begin
            fails++;
            $display("FAIL wait_state: dut%0d state=%b required %b within 40 cycles",
                     which, (which == 1) ? if1.state : if3.state, tgt);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        tests++;
        if (if1.state !== C_IDLE || ctl1 !== 26'd0 || if3.state !== C_IDLE || ctl3 !== 26'd0) begin
            fails++;
            $display("FAIL reset: st1=%b ctl1=%h st3=%b ctl3=%h required all 0",
                     if1.state, ctl1, if3.state, ctl3);
        end
        clear = 1'b0;
        mon_en = 1'b1;
        tick();
        tests++;
        if (if1.state !== C_IDLE || ctl1 !== 26'd0) begin
            fails++;
            $display("FAIL idle_hold: state=%b ctl=%h required 0000/0", if1.state, ctl1);
        end
    endtask

    task automatic test_mw1();
        run_sb(1, 1);
        tests++;
        if (n_write !== 1 || n_busy !== 9) begin
            fails++;
            $display("FAIL mw1_counts: write=%0d busy=%0d required 1 and 9", n_write, n_busy);
        end
    endtask

    task automatic test_mw3();
        run_sb(3, 3);
        tests++;
        if (n_busy !== 13 || n_read !== 3 || n_write !== 3 || n_pcin !== 1) begin
            fails++;
            $display("FAIL mw3_counts: busy=%0d read=%0d write=%0d pcin=%0d required 13/3/3/1",
                     n_busy, n_read, n_write, n_pcin);
        end
    endtask

    task automatic test_stall_t7();
        int wcnt = 0;
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        wait_st(1, C_T7);
        wcnt += int'(if1.Write);
        if1.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            wcnt += int'(if1.Write);
            tests++;
            if (if1.state !== C_T7 || if1.Write !== 1'b1) begin
                fails++;
                $display("FAIL stall_t7_hold: state=%b Write=%b required 1110/1", if1.state, if1.Write);
            end
        end
        if1.stall = 1'b0;
        tick();
        tests++;
        if (if1.state !== C_DONE || if1.Write !== 1'b0 || wcnt !== 5) begin
            fails++;
            $display("FAIL stall_t7_release: state=%b Write=%b width=%0d required 1111/0/5",
                     if1.state, if1.Write, wcnt);
        end
        wait_st(1, C_IDLE);
    endtask

    task automatic test_clear_abort();
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        wait_st(1, C_T7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++;
        if (if1.state !== C_IDLE || ctl1 !== 26'd0) begin
            fails++;
            $display("FAIL clear_abort: state=%b ctl=%h required 0000/0", if1.state, ctl1);
        end
        tick();
        tests++;
        if (if1.state !== C_IDLE || ctl1 !== 26'd0) begin
            fails++;
            $display("FAIL clear_after: state=%b ctl=%h required 0000/0", if1.state, ctl1);
        end
    endtask

    task automatic test_start_ignored();
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        wait_st(1, C_T3);
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        tests++;
        if (if1.state !== C_T4) begin
            fails++;
            $display("FAIL start_busy: state=%b required 1011", if1.state);
        end
        wait_st(1, C_DONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (if1.state !== C_IDLE || if1.busy !== 1'b0) begin
                fails++;
                $display("FAIL no_requeue: state=%b busy=%b required 0000/0", if1.state, if1.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        if1.start = 1'b1;
        tick();
        tests++;
        if (if1.state !== C_T0) begin
            fails++;
            $display("FAIL b2b_first: state=%b required 0111", if1.state);
        end
        do begin
            tick();
            n++;
        end while (if1.state !== C_T0 && n < 30);
        if1.start = 1'b0;
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL b2b_period: period=%0d required 10", n);
        end
        wait_st(1, C_IDLE);
    endtask

    task automatic test_datapath();
        dp_init = 1'b1; tick(); dp_init = 1'b0;
        if3.start = 1'b1; tick(); if3.start = 1'b0;
        tick();
        tests++;
        if (if3.state !== C_T1 || if3.PCin !== 1'b1) begin
            fails++;
            $display("FAIL t1_first: state=%b PCin=%b required 1000/1", if3.state, if3.PCin);
        end
        if3.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (if3.state !== C_T1 || if3.PCin !== 1'b0 || if3.Read !== 1'b1) begin
                fails++;
                $display("FAIL t1_stall: state=%b PCin=%b Read=%b required 1000/0/1",
                         if3.state, if3.PCin, if3.Read);
            end
        end
        if3.stall = 1'b0;
        wait_st(3, C_DONE);
        tests++;
        if (mem[8'h28] !== 32'h99 || PC !== 32'd1) begin
            fails++;
            $display("FAIL datapath_store: mem[28]=%h PC=%h required 00000099/00000001",
                     mem[8'h28], PC);
        end
        wait_st(3, C_IDLE);
    endtask

    initial begin
        if1.start = 1'b0; if1.stall = 1'b0;
        if3.start = 1'b0; if3.stall = 1'b0;
        test_reset();
        test_mw1();
        test_mw3();
        test_stall_t7();
        test_clear_abort();
        test_start_ignored();
        test_back_to_back();
        test_datapath();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/st_sequencer.md
Name: st_sequencer

Overview:
- Hard-wired control sequencer for the `st Ra, C(Rb)` store instruction. It is the memory-writing counterpart of the load sequence.
- It drives the DataPath control inputs through the full fetch/execute sequence. It ends by asserting Write so the Ra contents held in MDR are written to memory at address Rb+C.
- It sits between the top-level controller (start/stall) and the DataPath control port. It replaces hand-driven bench stimulus for store.

Parameters:
- ADD_OP, 5'b00011, Operator code for ALU add.
- MEM_WAIT, 1, cycles Read (T1) and Write (T7) are held; legal range 1..15.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  begin a store sequence; sampled only in IDLE
- stall  in  1  freeze state and wait counter while high
- PCout, Zlowout, MDRout, BAout, Cout, Rout  out  1 each  bus source enables
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin  out  1 each  register load enables
- IncPC  out  1  ALU PC-increment select
- Read  out  1  memory read strobe; also MDR input mux select (1 = memory, 0 = bus)
- Write  out  1  memory write strobe
- Operator  out  5  ALU operation code
- Gra, Grb, Grc  out  1 each  select-and-encode field selects
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- state  out  4  current state code, for debug and bench checking

Behaviour:
State codes:
- IDLE=0000, T0=0111, T1=1000, T2=1001, T3=1010, T4=1011, T5=1100, T6=1101, T7=1110, DONE=1111.
- The state register is the only architectural state, together with a 4-bit wait counter.

Reset:
- clear=1 at a rising edge sets state to IDLE and the wait counter to 0.
- Every output is 0 from that edge on, including Operator=0.
- clear takes priority over stall and start, and aborts any sequence mid-flight. No Write is asserted in the cycle after the reset edge.

Output decode:
- Outputs are pure functions of the registered state (Moore); no input-to-output combinational path.
- Any output not listed for a state is 0.
- IDLE: all 0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin only in the first cycle of T1; Read and MDRin for every cycle of T1.
- T2: MDRout, IRin.
- T3: Grb, BAout, Yin.
- T4: Cout, Zin, Operator=ADD_OP.
- T5: Zlowout, MARin.
- T6: Gra, Rout, MDRin (Read=0, so MDR loads from bus).
- T7: Write for every cycle of T7.
- DONE: done, all other controls 0.

Transitions (evaluated when clear=0):
- stall=1 holds state and counter; outputs are unchanged, except that PCin stays 0 on stalled cycles of T1, so PC is incremented exactly once.
- IDLE -> T0 when start=1; otherwise stay in IDLE.
- T0 -> T1; the counter loads MEM_WAIT-1.
- T1: if counter==0 go to T2, else decrement.
- T2 -> T3 -> T4 -> T5 -> T6 unconditionally.
- T6 -> T7; the counter loads MEM_WAIT-1.
- T7: if counter==0 go to DONE, else decrement.
- DONE -> IDLE.

start handling:
- start while busy is ignored and is not queued.
- start held high continuously launches a new sequence every (7 + 2*MEM_WAIT + 1) cycles, since IDLE occupies one cycle.

Latency:
- With start sampled at edge E0, T0 is active after E0.
- DONE is active after edge E(6 + 2*MEM_WAIT), given zero stalls.
- busy is high for 7 + 2*MEM_WAIT cycles.

Invariants:
- Read and Write are never both high.
- Exactly one bus source enable is high in T0–T7. T1 cycles after the first and all T7 cycles have none.
- Write pulse width equals MEM_WAIT cycles plus stalled cycles.

Test Plan:
- clear=1 for 2 cycles, then start pulse (MEM_WAIT=1) -> state walks 0111,1000,…,1110,1111,0000 on consecutive edges. done=1 exactly in the cycle after T7. Write=1 only in T7. Operator=5'b00011 only in T4.
- Full DataPath: R2=0x5, R4=0x99, IR word = st R4, 0x23(R2) -> memory[0x28]=0x99 after DONE; PC incremented by 1 exactly once.
- MEM_WAIT=3 -> Read high for 3 cycles in T1, PCin high only in the first of them, Write high for 3 cycles. busy high for 13 cycles.
- stall=1 for 4 cycles during T7 -> Write stays high for 5 cycles total, and state holds 1110 throughout.
- clear asserted during T7 -> next edge: state=0000 and all outputs 0. A start pulse issued during T3 is ignored; no second sequence follows DONE.
